// File: rtl/sc_decoder_if.sv
// Handshake and result bundle for the stochastic bitstream decoder.
// The master drives the stream and consumes the result; the decoder is the slave.
interface sc_decoder_if #(
  parameter int N       = 16,
  parameter int LOG_LEN = 8
);
  logic               start;
  logic               bit_in;
  logic               bit_valid;
  logic               busy;
  logic               out_valid;
  logic               out_ready;
  logic [N-1:0]       value;
  logic [LOG_LEN:0]   ones_count;

  modport master (
    output start, bit_in, bit_valid, out_ready,
    input  busy, out_valid, value, ones_count
  );

  modport slave (
    input  start, bit_in, bit_valid, out_ready,
    output busy, out_valid, value, ones_count
  );
endinterface

// File: rtl/sc_decoder.sv
// Counts the ones in a window of 2^LOG_LEN valid stochastic bits and reports
// the ratio as a Q0.N fraction, held until the consumer takes it.
module sc_decoder #(
  parameter int N       = 16,
  parameter int LOG_LEN = 8
) (
  input  logic          clk,
  input  logic          rst,
  sc_decoder_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, COUNT, HOLD} state_t;

  state_t               state_q, state_d;
  logic [LOG_LEN-1:0]   cnt_q, cnt_d;
  logic [LOG_LEN:0]     acc_q, acc_d;
  logic [LOG_LEN:0]     ones_q, ones_d;
  logic [N-1:0]         value_q, value_d;

  // A full window of ones (only case with the top bit set) would overflow Q0.N.
  function automatic logic [N-1:0] sat_value(input logic [LOG_LEN:0] ones);
    logic [N+LOG_LEN:0] wide;
    wide = (N+LOG_LEN+1)'(ones) << (N-LOG_LEN);
    if (ones[LOG_LEN]) return {N{1'b1}};
    return wide[N-1:0];
  endfunction

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    ones_d  = ones_q;
    value_d = value_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          state_d = COUNT;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      COUNT: begin
        if (bus.bit_valid) begin
          cnt_d = cnt_q + LOG_LEN'(1);
          acc_d = acc_q + (LOG_LEN+1)'(bus.bit_in);
          // Counter at all-ones means this is the last bit of the window.
          if (&cnt_q) begin
            state_d = HOLD;
            ones_d  = acc_d;
            value_d = sat_value(acc_d);
          end
        end
      end
      HOLD: begin
        if (bus.out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      ones_q  <= '0;
      value_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      ones_q  <= ones_d;
      value_q <= value_d;
    end
  end

  assign bus.busy       = (state_q != IDLE);
  assign bus.out_valid  = (state_q == HOLD);
  assign bus.value      = value_q;
  assign bus.ones_count = ones_q;

endmodule

// File: tb/tb_sc_decoder.sv
// Directed and randomized windows for sc_decoder, checked against a
// ones-counting reference model of the decoded fraction.
module tb_sc_decoder;
  localparam int N       = 16;
  localparam int LOG_LEN = 8;
  localparam int L       = 1 << LOG_LEN;

  logic clk = 1'b0;
  logic rst;

  sc_decoder_if #(.N(N), .LOG_LEN(LOG_LEN)) bus ();

  sc_decoder #(.N(N), .LOG_LEN(LOG_LEN)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks   = 0;
  int   failures = 0;
  logic pat [L];
  int   exp_ones;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: fraction of ones scaled to 2^N, clamped to the largest Q0.N code.
  function automatic int exp_value(input int ones);
    longint scaled;
    scaled = (longint'(ones) * (longint'(1) << N)) / L;
    if (scaled > (longint'(1) << N) - 1) scaled = (longint'(1) << N) - 1;
    return int'(scaled);
  endfunction

  // mode 0 zeros, 1 ones, 2 alternating 1,0, 3 random, 4 exactly k ones scattered
  task automatic fill(input int mode, input int k);
    int placed;
    int j;
    for (int i = 0; i < L; i++) begin
      case (mode)
        0:       pat[i] = 1'b0;
        1:       pat[i] = 1'b1;
        2:       pat[i] = (i % 2 == 0);
        3:       pat[i] = logic'($urandom_range(0, 1));
        default: pat[i] = 1'b0;
      endcase
    end
    if (mode == 4) begin
      placed = 0;
      while (placed < k) begin
        j = int'($urandom_range(0, L - 1));
        if (!pat[j]) begin
          pat[j] = 1'b1;
          placed++;
        end
      end
    end
    exp_ones = 0;
    for (int i = 0; i < L; i++) exp_ones += int'(pat[i]);
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("start_busy", int'(bus.busy), 1);
    chk("start_no_valid", int'(bus.out_valid), 0);
  endtask

  // stall 0: none, 1: every 3rd cycle idle, 2: random idle cycles
  task automatic feed(input int stall);
    int   idx = 0;
    int   cyc = 0;
    logic v;
    while (idx < L && cyc < 8 * L) begin
      if (stall == 1)      v = (cyc % 3 != 2);
      else if (stall == 2) v = ($urandom_range(0, 3) != 0);
      else                 v = 1'b1;
      bus.bit_valid = v;
      bus.bit_in    = v ? pat[idx] : logic'($urandom_range(0, 1));
      if (v && idx == L - 1) chk("pre_last_out_valid", int'(bus.out_valid), 0);
      @(negedge clk);
      if (v) idx++;
      cyc++;
    end
    bus.bit_valid = 1'b0;
    bus.bit_in    = 1'b0;
    chk("feed_bound", idx, L);
    chk("out_valid_latency", int'(bus.out_valid), 1);
    chk("ones_count", int'(bus.ones_count), exp_ones);
    chk("value", int'(bus.value), exp_value(exp_ones));
  endtask

  task automatic release_result();
    int v_keep;
    int o_keep;
    v_keep = int'(bus.value);
    o_keep = int'(bus.ones_count);
    bus.out_ready = 1'b1;
    @(negedge clk);
    bus.out_ready = 1'b0;
    chk("release_out_valid", int'(bus.out_valid), 0);
    chk("release_busy", int'(bus.busy), 0);
    chk("release_value_kept", int'(bus.value), v_keep);
    chk("release_ones_kept", int'(bus.ones_count), o_keep);
  endtask

  initial begin
    rst           = 1'b1;
    bus.start     = 1'b0;
    bus.bit_in    = 1'b0;
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_busy", int'(bus.busy), 0);
    chk("rst_out_valid", int'(bus.out_valid), 0);
    chk("rst_value", int'(bus.value), 0);
    chk("rst_ones", int'(bus.ones_count), 0);
    rst = 1'b0;
    @(negedge clk);

    // All zeros
    fill(0, 0);
    do_start();
    feed(0);
    chk("zeros_value", int'(bus.value), 32'h0000);
    release_result();

    // All ones saturates
    @(negedge clk);
    fill(1, 0);
    do_start();
    feed(0);
    chk("ones_count_full", int'(bus.ones_count), 256);
    chk("ones_value_sat", int'(bus.value), 32'hFFFF);
    release_result();

    // Alternating with every third cycle stalled
    fill(2, 0);
    do_start();
    feed(1);
    chk("alt_value", int'(bus.value), 32'h8000);
    chk("alt_ones", int'(bus.ones_count), 128);
    release_result();

    // 120 ones, consumer stalls 5 cycles, start pulsed in HOLD
    fill(4, 120);
    do_start();
    feed(2);
    for (int i = 0; i < 5; i++) begin
      bus.out_ready = 1'b0;
      bus.start     = (i == 2);
      bus.bit_valid = logic'($urandom_range(0, 1));
      bus.bit_in    = logic'($urandom_range(0, 1));
      @(negedge clk);
      chk("hold_out_valid", int'(bus.out_valid), 1);
      chk("hold_value", int'(bus.value), 32'h7800);
      chk("hold_ones", int'(bus.ones_count), 120);
    end
    bus.start     = 1'b0;
    bus.bit_valid = 1'b0;
    release_result();

    // Back-to-back random windows, start in the first IDLE cycle
    for (int w = 0; w < 3; w++) begin
      fill(3, 0);
      do_start();
      feed(2);
      release_result();
    end

    // Result retained in IDLE; stream and out_ready ignored
    for (int i = 0; i < 3; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = logic'($urandom_range(0, 1));
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("idle_busy", int'(bus.busy), 0);
      chk("idle_out_valid", int'(bus.out_valid), 0);
      chk("idle_value_kept", int'(bus.value), exp_value(exp_ones));
    end
    bus.bit_valid = 1'b0;
    bus.out_ready = 1'b0;

    // Abort after 100 valid bits with an asynchronous reset
    fill(1, 0);
    do_start();
    for (int i = 0; i < 100; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      @(negedge clk);
    end
    #2 rst = 1'b1;
    #1;
    chk("async_busy", int'(bus.busy), 0);
    chk("async_out_valid", int'(bus.out_valid), 0);
    chk("async_value", int'(bus.value), 0);
    chk("async_ones", int'(bus.ones_count), 0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      bus.bit_valid = 1'b1;
      bus.bit_in    = 1'b1;
      @(negedge clk);
      chk("post_rst_idle", int'(bus.busy), 0);
    end
    bus.bit_valid = 1'b0;

    // Start honoured on the first edge after reset release
    rst = 1'b1;
    @(negedge clk);
    rst       = 1'b0;
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    chk("first_edge_start", int'(bus.busy), 1);
    feed(0);
    chk("post_abort_value", int'(bus.value), 32'hFFFF);
    chk("post_abort_ones", int'(bus.ones_count), 256);
    release_result();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sc_decoder.md
SC_DECODER -- requirements
Module: sc_decoder

Interface
REQ-001 SHALL have parameter N, default 16: output width, Q0.N unsigned fraction (0 <= x < 1).
REQ-002 SHALL have parameter LOG_LEN, default 8: stream length L = 2^LOG_LEN bits; legal range 1 <= LOG_LEN <= N.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port start  input  1  begin a new decode window; sampled only in IDLE.
REQ-006 SHALL have port bit_in  input  1  stochastic bitstream sample.
REQ-007 SHALL have port bit_valid  input  1  bit_in is valid this cycle; low stalls the window.
REQ-008 SHALL have port busy  output  1  high in COUNT and HOLD.
REQ-009 SHALL have port out_valid  output  1  result available; high only in HOLD.
REQ-010 SHALL have port out_ready  input  1  consumer accepts the result.
REQ-011 SHALL have port value  output  N  decoded Q0.N estimate of P(bit_in=1).
REQ-012 SHALL have port ones_count  output  LOG_LEN+1  raw count of ones in the window, 0..L.

Function
REQ-013 SHALL implement FSM states IDLE, COUNT, HOLD; the state, counters and outputs are registered.
REQ-014 IDLE: start=1 SHALL move to COUNT next cycle and clear sample counter and ones accumulator; start=0 SHALL stay in IDLE.
REQ-015 COUNT: each cycle with bit_valid=1 SHALL increment the sample counter by 1 and add bit_in to the ones accumulator; cycles with bit_valid=0 SHALL change neither.
REQ-016 COUNT: when the L-th valid bit is accepted, the SHALL move to HOLD on the next edge with ones_count and value updated on that same edge (latency: 1 cycle after the last accepted bit).
REQ-017 value SHALL equal ones_count << (N-LOG_LEN), truncated to N bits, except ones_count = L SHALL saturate value to 2^N-1.
REQ-018 Accumulator SHALL be LOG_LEN+1 bits wide; the sample counter SHALL not wrap mid-window (exactly L valid bits per window).
REQ-019 HOLD: out_valid=1; value and ones_count SHALL be stable until the handshake completes.
REQ-020 HOLD with out_ready=1 SHALL complete the transfer and move to IDLE next cycle; out_valid SHALL drop in that cycle.
REQ-021 out_ready while out_valid=0 SHALL be ignored.
REQ-022 start during COUNT or HOLD SHALL be ignored (no restart, no state change).
REQ-023 bit_in/bit_valid in IDLE or HOLD SHALL be ignored.
REQ-024 Back-to-back windows: start asserted in the first IDLE cycle after a transfer SHALL begin a new window; no bit from the prior window carries over.
REQ-025 value and ones_count SHALL retain the last result in IDLE until the next window completes.

Reset
REQ-026 rst=1 SHALL immediately, without a clock edge, force state IDLE, busy=0, out_valid=0, value=0, ones_count=0, and clear the internal counters.
REQ-027 Reset asserted mid-COUNT or in HOLD SHALL abandon the window; after release, no result SHALL appear until a new start followed by L valid bits.
REQ-028 The first rising edge after rst deasserts SHALL be a normal IDLE cycle (start honoured).

Verification (N=16, LOG_LEN=8, L=256)
REQ-029 start, then 256 valid zeros -> out_valid, ones_count=0, value=0x0000.
REQ-030 start, then 256 valid ones -> ones_count=256, value=0xFFFF (saturated).
REQ-031 start, then alternating 1,0 for 256 valid bits, with bit_valid=0 on every 3rd cycle -> ones_count=128, value=0x8000; out_valid exactly 1 cycle after the 256th accepted bit.
REQ-032 Window with 120 ones, out_ready low 5 cycles in HOLD, start pulsed during HOLD -> value=0x7800 held stable for all 5 cycles; start ignored; IDLE one cycle after out_ready=1.
REQ-033 rst pulsed asynchronously after 100 valid bits -> outputs zero at once; a new start plus 256 ones -> value=0xFFFF, with no residue from the aborted window.
